// File: rtl/seq_divider.sv
// Multicycle restoring divider, one quotient bit per clock, signed or unsigned per operation.
// Define SEQ_DIVIDER_OVF_EN to add the overflow output for signed -2^(DVD_W-1) / -1.
module seq_divider #(
   parameter int unsigned DVD_W = 64,
   parameter int unsigned DVS_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             valid,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             div_by_zero
`ifdef SEQ_DIVIDER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int unsigned CntW = $clog2(DVD_W + 1);

   typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

   state_e state_q, state_d;

   logic [DVD_W-1:0] dvd_q;
   logic [DVS_W-1:0] dvs_q;
   logic             sgn_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic [DVD_W-1:0] work_q;
   logic [DVS_W-1:0] dvs_abs_q;
   logic [DVS_W-1:0] prem_q;
   logic [CntW-1:0]  cnt_q;

   logic             dvs_zero;
   logic [DVD_W-1:0] dvd_abs;
   logic [DVS_W-1:0] dvs_abs;
   logic [DVS_W:0]   rem_shift;
   logic [DVS_W-1:0] diff;
   logic             fits;

   always_comb begin
      dvs_zero  = (dvs_q == '0);
      dvd_abs   = (sgn_q & dvd_q[DVD_W-1]) ? -dvd_q : dvd_q;
      dvs_abs   = (sgn_q & dvs_q[DVS_W-1]) ? -dvs_q : dvs_q;
      // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
      rem_shift = {prem_q, work_q[DVD_W-1]};
      fits      = (rem_shift >= {1'b0, dvs_abs_q});
      // modulo subtraction is exact whenever fits is set
      diff      = rem_shift[DVS_W-1:0] - dvs_abs_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StPrep;
         StPrep:  state_d = dvs_zero ? StIdle : StIter;
         StIter:  if (cnt_q == CntW'(1)) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         sgn_q       <= 1'b0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         work_q      <= '0;
         dvs_abs_q   <= '0;
         prem_q      <= '0;
         cnt_q       <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_OVF_EN
         overflow    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  dvd_q       <= dividend;
                  dvs_q       <= divisor;
                  sgn_q       <= is_signed;
                  neg_q_q     <= is_signed & (dividend[DVD_W-1] ^ divisor[DVS_W-1]);
                  neg_r_q     <= is_signed & dividend[DVD_W-1];
                  busy        <= 1'b1;
                  valid       <= 1'b0;
                  div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_OVF_EN
                  overflow    <= 1'b0;
`endif
               end
            end
            StPrep: begin
               if (dvs_zero) begin
                  quotient    <= '1;
                  remainder   <= dvd_q[DVS_W-1:0];
                  div_by_zero <= 1'b1;
                  valid       <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  work_q    <= dvd_abs;
                  dvs_abs_q <= dvs_abs;
                  prem_q    <= '0;
                  cnt_q     <= CntW'(DVD_W);
               end
            end
            StIter: begin
               work_q <= {work_q[DVD_W-2:0], fits};
               prem_q <= fits ? diff : rem_shift[DVS_W-1:0];
               cnt_q  <= cnt_q - CntW'(1);
            end
            StFix: begin
               quotient  <= neg_q_q ? -work_q : work_q;
               remainder <= neg_r_q ? -prem_q : prem_q;
               valid     <= 1'b1;
               busy      <= 1'b0;
`ifdef SEQ_DIVIDER_OVF_EN
               overflow  <= sgn_q & (dvd_q == {1'b1, {(DVD_W-1){1'b0}}}) & (&dvs_q);
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: table of operations plus hand-written hammer and reset cases.
// Overflow checks are compiled in when SEQ_DIVIDER_OVF_EN is defined.
module tb_seq_divider;

   localparam int unsigned DVD_W = 64;
   localparam int unsigned DVS_W = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic             is_signed;
   logic [DVD_W-1:0] dividend;
   logic [DVS_W-1:0] divisor;
   logic             busy;
   logic             valid;
   logic [DVD_W-1:0] quotient;
   logic [DVS_W-1:0] remainder;
   logic             div_by_zero;
`ifdef SEQ_DIVIDER_OVF_EN
   logic             overflow;
`endif

   seq_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .valid       (valid),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
`ifdef SEQ_DIVIDER_OVF_EN
      ,
      .overflow    (overflow)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic             sgn;
      logic [DVD_W-1:0] dvd;
      logic [DVS_W-1:0] dvs;
      logic [DVD_W-1:0] q;
      logic [DVS_W-1:0] r;
      logic             dz;
      logic             ovf;
   } vec_t;

   int               total = 0;
   int               bad = 0;
   logic [DVD_W-1:0] last_q = '0;
   logic [DVS_W-1:0] last_r = '0;
   vec_t             vecs[12];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // One operation; hammer keeps start high with junk operands while the divide runs.
   task automatic run_op(input vec_t v, input bit hammer);
      int n;
      bit held_ok;
      @(negedge clock);
      is_signed = v.sgn;
      dividend  = v.dvd;
      divisor   = v.dvs;
      start     = 1'b1;
      @(posedge clock);
      #1;
      check("accept_busy", 64'(busy), 64'd1);
      check("accept_valid", 64'(valid), 64'd0);
      check("held_q", quotient, last_q);
      check("held_r", 64'(remainder), 64'(last_r));
      if (hammer) begin
         is_signed = 1'b1;
         dividend  = 64'd999;
         divisor   = 32'd3;
      end else begin
         start = 1'b0;
      end
      n = 0;
      held_ok = 1'b1;
      while (valid !== 1'b1 && n < 200) begin
         @(posedge clock);
         #1;
         n++;
         if (valid !== 1'b1 && (busy !== 1'b1 || quotient !== last_q)) held_ok = 1'b0;
      end
      start = 1'b0;
      check("latency", 64'(n), v.dz ? 64'd1 : 64'(DVD_W + 2));
      check("busy_hold", 64'(held_ok), 64'd1);
      check("done_busy", 64'(busy), 64'd0);
      check("quotient", quotient, v.q);
      check("remainder", 64'(remainder), 64'(v.r));
      check("div_by_zero", 64'(div_by_zero), 64'(v.dz));
`ifdef SEQ_DIVIDER_OVF_EN
      check("overflow", 64'(overflow), 64'(v.ovf));
`endif
      last_q = v.q;
      last_r = v.r;
   endtask

   initial begin
      vec_t op100;
      vecs[0]  = '{1'b0, 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 32'd2,
                   64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 64'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 32'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,
                   64'h0000_0001_0000_0001, 32'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 32'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 64'd1234, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_04D2, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 64'd14, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF,
                   64'h8000_0000_0000_0000, 32'd0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 64'd5, 32'd9, 64'd0, 32'd5, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 32'd0,
                   64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 64'h8000_0000_0000_0000, 32'd3,
                   64'h2AAA_AAAA_AAAA_AAAA, 32'd2, 1'b0, 1'b0};
      op100 = vecs[0];

      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_q", quotient, 64'd0);
      check("rst_dz", 64'(div_by_zero), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run_op(vecs[i], 1'b0);

      // start held high throughout must not disturb the in-flight divide
      run_op(op100, 1'b1);

      // reset sampled at E30 aborts the divide
      @(negedge clock);
      is_signed = 1'b0;
      dividend  = 64'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (29) @(posedge clock);
      #1;
      check("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_valid", 64'(valid), 64'd0);
      check("abort_q", quotient, 64'd0);
      check("abort_r", 64'(remainder), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      check("abort_no_valid", 64'(valid), 64'd0);
      last_q = '0;
      last_r = '0;
      run_op(op100, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
